// File: rtl/buffer_swap_scheduler_pkg.sv
// Shared types and defaults for the frame-store swap scheduler.
// Imported by ack_watchdog and buffer_swap_scheduler.
package swap_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SWAP       = 3'd1,
    SENDING    = 3'd2,
    WAIT_FRAME = 3'd3,
    ERROR      = 3'd4
  } swap_state_t;

  localparam int ACK_TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/buffer_swap_scheduler_ack_watchdog.sv
// Swap acknowledge watchdog: a down-counter loaded on swap issue that flags
// a terminal count if Matrix_Buffer never acknowledges.
module ack_watchdog
  import swap_sched_pkg::*;
#(
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_ack,
  output logic o_timeout
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_active;
  logic          w_expired;

  // r_cnt holds ACK_TIMEOUT during the trigger cycle and reaches zero on
  // cycle trigger+ACK_TIMEOUT, the last cycle an ack is still honoured.
  assign w_expired = r_active && (r_cnt == '0);
  assign o_timeout = w_expired;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_cnt    <= CW'(ACK_TIMEOUT);
      r_active <= 1'b1;
    end else if (r_active) begin
      if (i_ack || w_expired) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/buffer_swap_scheduler.sv
// Double-buffer swap sequencer between the HDMI writer and SPI Output_Logic.
// Optional statistics counters are built when SWAP_STATS_EN is defined.
//
// state      | meaning
// IDLE       | no image in flight, waiting for a frame with valid dimensions
// SWAP       | swap trigger issued, waiting for Matrix_Buffer ack
// SENDING    | Output_Logic transmitting the front bank
// WAIT_FRAME | front image sent, no repeat, waiting for a new frame
// ERROR      | ack timeout seen; frozen until reset
module buffer_swap_scheduler
  import swap_sched_pkg::*;
#(
  parameter int ACK_TIMEOUT      = ACK_TIMEOUT_DEFAULT,
  parameter int REPEAT_ON_STARVE = 1,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_frame_written,
  input  logic I_image_valid,
  input  logic I_image_sent,
  input  logic I_swap_ack,
  output logic O_swap_trigger,
  output logic O_start_image,
  output logic O_frame_dropped,
  output logic O_busy,
  output logic O_error
`ifdef SWAP_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] O_drop_count,
  output logic [COUNT_WIDTH-1:0] O_repeat_count
`endif
);

  swap_state_t r_state;
  logic        r_pending;
  logic        r_swap_trigger;
  logic        r_start_image;
  logic        r_frame_dropped;
  logic        r_busy;
  logic        r_error;

  logic w_pending_eff;
  logic w_drop;
  logic w_ack_ok;
  logic w_issue;
  logic w_repeat;
  logic w_timeout;

  // A frame completing this cycle counts as pending for the swap decision,
  // which gives the one-cycle frame_written -> trigger latency.
  assign w_pending_eff = r_pending | I_frame_written;
  assign w_drop        = r_pending & I_frame_written;

  // The trigger cycle itself is excluded from ack acceptance.
  assign w_ack_ok = (r_state == SWAP) && I_swap_ack && !r_swap_trigger;

  always_comb begin
    w_issue  = 1'b0;
    w_repeat = 1'b0;
    case (r_state)
      IDLE, WAIT_FRAME: w_issue = w_pending_eff & I_image_valid;
      SENDING: begin
        w_issue  = I_image_sent & I_image_valid & w_pending_eff;
        w_repeat = I_image_sent & I_image_valid & !w_pending_eff &
                   (REPEAT_ON_STARVE != 0);
      end
      default: begin
        w_issue  = 1'b0;
        w_repeat = 1'b0;
      end
    endcase
  end

  ack_watchdog #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_watchdog (
    .i_clk    (I_clk),
    .i_rst    (I_rst),
    .i_start  (w_issue),
    .i_ack    (w_ack_ok),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state         <= IDLE;
      r_pending       <= 1'b0;
      r_swap_trigger  <= 1'b0;
      r_start_image   <= 1'b0;
      r_frame_dropped <= 1'b0;
      r_busy          <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_swap_trigger  <= 1'b0;
      r_start_image   <= 1'b0;
      r_frame_dropped <= w_drop;
      r_pending       <= w_issue ? 1'b0 : w_pending_eff;

      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state        <= SWAP;
            r_swap_trigger <= 1'b1;
            r_busy         <= 1'b1;
          end
        end
        SWAP: begin
          if (w_ack_ok) begin
            r_state       <= SENDING;
            r_start_image <= 1'b1;
          end else if (w_timeout) begin
            r_state <= ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end
        end
        SENDING: begin
          if (I_image_sent) begin
            if (!I_image_valid) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else if (w_issue) begin
              r_state        <= SWAP;
              r_swap_trigger <= 1'b1;
            end else if (w_repeat) begin
              r_start_image <= 1'b1;
            end else begin
              r_state <= WAIT_FRAME;
              r_busy  <= 1'b0;
            end
          end
        end
        WAIT_FRAME: begin
          if (w_issue) begin
            r_state        <= SWAP;
            r_swap_trigger <= 1'b1;
            r_busy         <= 1'b1;
          end else if (!I_image_valid) begin
            r_state <= IDLE;
          end
        end
        ERROR: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign O_swap_trigger  = r_swap_trigger;
  assign O_start_image   = r_start_image;
  assign O_frame_dropped = r_frame_dropped;
  assign O_busy          = r_busy;
  assign O_error         = r_error;

`ifdef SWAP_STATS_EN
  logic [COUNT_WIDTH-1:0] r_drop_count;
  logic [COUNT_WIDTH-1:0] r_repeat_count;

  // Counters advance on the same edge that registers their pulse and stick at all-ones.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_drop_count   <= '0;
      r_repeat_count <= '0;
    end else begin
      if (w_drop && (r_drop_count != '1)) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
      if (w_repeat && (r_repeat_count != '1)) begin
        r_repeat_count <= r_repeat_count + 1'b1;
      end
    end
  end

  assign O_drop_count   = r_drop_count;
  assign O_repeat_count = r_repeat_count;
`endif

endmodule

// File: tb/tb_buffer_swap_scheduler.sv
// Bench for buffer_swap_scheduler: two instances (repeat / wait-on-starve)
// share stimulus and are compared every cycle against a behavioural model.
module tb_buffer_swap_scheduler;

  localparam int TO_A = 8;
  localparam int TO_B = 5;
  localparam int CNT_MAX = 65535;

  localparam int P_IDLE = 0;
  localparam int P_SWAP = 1;
  localparam int P_SEND = 2;
  localparam int P_WAIT = 3;
  localparam int P_ERR  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic in_rst = 1'b1;
  logic in_fw = 1'b0;
  logic in_valid = 1'b0;
  logic in_sent = 1'b0;
  logic in_ack = 1'b0;

  logic [1:0] trig_o, start_o, drop_o, busy_o, err_o;
`ifdef SWAP_STATS_EN
  logic [15:0] dcnt_o [2];
  logic [15:0] rcnt_o [2];
`endif

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    int phase;
    bit pend;
    int age;
    bit trig;
    bit start;
    bit drop;
    bit busy;
    bit err;
    int dcnt;
    int rcnt;
  } mdl_t;

  mdl_t m[2];
  int   to_p[2] = '{TO_A, TO_B};
  bit   rep_p[2] = '{1'b1, 1'b0};

  buffer_swap_scheduler #(
    .ACK_TIMEOUT(TO_A), .REPEAT_ON_STARVE(1), .COUNT_WIDTH(16)
  ) dut_a (
    .I_clk(clk), .I_rst(in_rst), .I_frame_written(in_fw),
    .I_image_valid(in_valid), .I_image_sent(in_sent), .I_swap_ack(in_ack),
    .O_swap_trigger(trig_o[0]), .O_start_image(start_o[0]),
    .O_frame_dropped(drop_o[0]), .O_busy(busy_o[0]), .O_error(err_o[0])
`ifdef SWAP_STATS_EN
    , .O_drop_count(dcnt_o[0]), .O_repeat_count(rcnt_o[0])
`endif
  );

  buffer_swap_scheduler #(
    .ACK_TIMEOUT(TO_B), .REPEAT_ON_STARVE(0), .COUNT_WIDTH(16)
  ) dut_b (
    .I_clk(clk), .I_rst(in_rst), .I_frame_written(in_fw),
    .I_image_valid(in_valid), .I_image_sent(in_sent), .I_swap_ack(in_ack),
    .O_swap_trigger(trig_o[1]), .O_start_image(start_o[1]),
    .O_frame_dropped(drop_o[1]), .O_busy(busy_o[1]), .O_error(err_o[1])
`ifdef SWAP_STATS_EN
    , .O_drop_count(dcnt_o[1]), .O_repeat_count(rcnt_o[1])
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next-cycle outputs from the behavioural rules, given this cycle's inputs.
  task automatic step_model(input int k);
    bit pe;
    bit go;
    if (in_rst) begin
      m[k] = '{default: 0};
      return;
    end
    pe = m[k].pend | in_fw;
    go = 1'b0;
    m[k].trig  = 1'b0;
    m[k].start = 1'b0;
    m[k].drop  = m[k].pend & in_fw;
    if (m[k].drop && m[k].dcnt < CNT_MAX) m[k].dcnt++;
    case (m[k].phase)
      P_IDLE: go = pe & in_valid;
      P_SWAP: begin
        if (in_ack && m[k].age > 0) begin
          m[k].start = 1'b1;
          m[k].phase = P_SEND;
        end else if (m[k].age == to_p[k]) begin
          m[k].phase = P_ERR;
        end
        m[k].age++;
      end
      P_SEND: begin
        if (in_sent) begin
          if (!in_valid) m[k].phase = P_IDLE;
          else if (pe) go = 1'b1;
          else if (rep_p[k]) begin
            m[k].start = 1'b1;
            if (m[k].rcnt < CNT_MAX) m[k].rcnt++;
          end else m[k].phase = P_WAIT;
        end
      end
      P_WAIT: begin
        if (pe && in_valid) go = 1'b1;
        else if (!in_valid) m[k].phase = P_IDLE;
      end
      default: ;
    endcase
    m[k].pend = go ? 1'b0 : pe;
    if (go) begin
      m[k].phase = P_SWAP;
      m[k].trig  = 1'b1;
      m[k].age   = 0;
    end
    m[k].busy = (m[k].phase == P_SWAP) || (m[k].phase == P_SEND);
    m[k].err  = (m[k].phase == P_ERR);
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("trig[%0d]", k),  trig_o[k],  m[k].trig);
      chk($sformatf("start[%0d]", k), start_o[k], m[k].start);
      chk($sformatf("drop[%0d]", k),  drop_o[k],  m[k].drop);
      chk($sformatf("busy[%0d]", k),  busy_o[k],  m[k].busy);
      chk($sformatf("err[%0d]", k),   err_o[k],   m[k].err);
`ifdef SWAP_STATS_EN
      chk($sformatf("dcnt[%0d]", k),  dcnt_o[k],  m[k].dcnt);
      chk($sformatf("rcnt[%0d]", k),  rcnt_o[k],  m[k].rcnt);
`endif
    end
  endtask

  task automatic cyc(input bit fw, input bit v, input bit sent, input bit ack, input bit rst);
    @(negedge clk);
    in_fw    = fw;
    in_valid = v;
    in_sent  = sent;
    in_ack   = ack;
    in_rst   = rst;
    @(posedge clk);
    step_model(0);
    step_model(1);
    #1;
    compare_all();
  endtask

  initial begin
    #20ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit v;
    // Reset state
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("rst_trig", trig_o[0], 0);
    chk("rst_start", start_o[0], 0);
    chk("rst_busy", busy_o[0], 0);
    chk("rst_err", err_o[1], 0);

    // Frame -> trigger next cycle, ack 4 cycles later -> start next cycle
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("first_trig_a", trig_o[0], 1);
    chk("first_trig_b", trig_o[1], 1);
    chk("model_first_trig", m[0].trig, 1);
    cyc(0, 1, 0, 0, 0);
    chk("trig_one_cycle", trig_o[0], 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    chk("ack_start_a", start_o[0], 1);
    chk("ack_busy_a", busy_o[0], 1);
    chk("ack_start_b", start_o[1], 1);

    // Two frames while sending: one drop, one swap
    cyc(1, 1, 0, 0, 0);
    chk("no_drop_first", drop_o[0], 0);
    cyc(1, 1, 0, 0, 0);
    chk("drop_second", drop_o[0], 1);
    cyc(0, 1, 1, 0, 0);
    chk("swap_after_sent", trig_o[0], 1);
    chk("drop_once", drop_o[0], 0);
`ifdef SWAP_STATS_EN
    chk("drop_count", dcnt_o[0], 1);
`endif
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    chk("start2_a", start_o[0], 1);

    // Starvation: repeat on A, wait on B
    cyc(0, 1, 1, 0, 0);
    chk("repeat_start_a", start_o[0], 1);
    chk("wait_nostart_b", start_o[1], 0);
    chk("wait_notbusy_b", busy_o[1], 0);
`ifdef SWAP_STATS_EN
    chk("repeat_count", rcnt_o[0], 1);
`endif
    cyc(1, 1, 0, 0, 0);
    chk("wait_frame_trig_b", trig_o[1], 1);
    chk("sending_no_trig_a", trig_o[0], 0);

    // Frame coinciding with swap issue stays pending
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 1, 0);
    chk("coinc_start_b", start_o[1], 1);
    cyc(0, 1, 1, 0, 0);
    chk("coinc_reswap_b", trig_o[1], 1);

    // Ack timeout
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    chk("to_trig", trig_o[0], 1);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0, 0, 0);
      chk($sformatf("to_noerr_%0d", i), err_o[0], 0);
    end
    cyc(0, 1, 0, 0, 0);
    chk("to_err", err_o[0], 1);
    cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 1, 1, 0);
    chk("err_no_trig", trig_o[0], 0);
    chk("err_no_start", start_o[0], 0);
    chk("err_sticky", err_o[0], 1);
    cyc(0, 1, 0, 0, 1);
    chk("err_cleared", err_o[0], 0);

    // Randomised traffic
    v = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39, 0) == 0) v = ~v;
      cyc($urandom_range(7, 0) == 0, v, $urandom_range(5, 0) == 0,
          $urandom_range(3, 0) == 0, $urandom_range(299, 0) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/buffer_swap_scheduler.md
# buffer_swap_scheduler

Sequences the double-buffered frame store between the HDMI input path and the SPI output path, all in the `sys_clk_27MHz` domain. It decides when the Matrix_Buffer banks swap, based on "frame fully written" events from the writer side and "image fully transmitted" events from Output_Logic. It drives the previously undriven `swap_trigger` and tells Output_Logic when to start a new image. It handles starvation (no new frame yet) and overrun (writer finishes again before a swap), and flags a buffer that never acknowledges a swap.

## Interface
Parameters:
- `ACK_TIMEOUT`, 1024: max cycles from `O_swap_trigger` to `I_swap_ack` before error.
- `REPEAT_ON_STARVE`, 1: 1 = resend the current front image when no new frame is pending; 0 = wait for a new frame.
- `COUNT_WIDTH`, 16: width of the statistics counters.

Ports:
- `I_clk`, in, 1: `sys_clk_27MHz`; the only clock.
- `I_rst`, in, 1: synchronous, active-high reset.
- `I_frame_written`, in, 1: one-cycle pulse; the writer completed a frame into the back bank. Already synchronised to `I_clk`.
- `I_image_valid`, in, 1: level; image dimensions from Input_Logic are valid.
- `I_image_sent`, in, 1: one-cycle pulse; Output_Logic finished transmitting the front image.
- `I_swap_ack`, in, 1: one-cycle pulse; Matrix_Buffer completed the swap.
- `O_swap_trigger`, out, 1: one-cycle pulse to Matrix_Buffer `I_swap_trigger`.
- `O_start_image`, out, 1: one-cycle pulse; Output_Logic starts sending the front bank.
- `O_frame_dropped`, out, 1: one-cycle pulse; a pending frame was overwritten.
- `O_busy`, out, 1: high in SWAP or SENDING.
- `O_error`, out, 1: sticky; an ack timeout occurred.
- `O_drop_count`, `O_repeat_count`, out, COUNT_WIDTH: only with `SWAP_STATS_EN`.

## Operation
- The `pending` flag means the back bank holds a complete, unswapped frame.
  - Set by `I_frame_written`.
  - Cleared in the cycle `O_swap_trigger` is issued.
  - If `I_frame_written` arrives while `pending`=1, pulse `O_frame_dropped`. `pending` stays 1; the newest frame wins.
  - If `I_frame_written` coincides with swap issue, `pending` stays 1.
- FSM states: IDLE, SWAP, SENDING, WAIT_FRAME, ERROR.
- IDLE:
  - `pending` & `I_image_valid` → SWAP.
- SWAP:
  - `O_swap_trigger` pulses on the entry cycle and the watchdog starts.
  - `I_swap_ack` → SENDING with an `O_start_image` pulse.
  - Watchdog reaching `ACK_TIMEOUT` → ERROR.
  - `I_image_sent` is ignored here.
- SENDING, on `I_image_sent`:
  - `I_image_valid`=0 → IDLE.
  - else `pending` → SWAP.
  - else `REPEAT_ON_STARVE`=1 → stay in SENDING, pulse `O_start_image`.
  - else → WAIT_FRAME.
- WAIT_FRAME:
  - `pending` & `I_image_valid` → SWAP.
  - `I_image_valid`=0 → IDLE.
- ERROR:
  - `O_error`=1; no further triggers or starts.
  - Exit only via `I_rst`.
- Any `I_swap_ack` outside SWAP is ignored.

## Timing
- All outputs are registered. Reset values: every output 0, state IDLE, `pending`=0, counters 0.
- `I_frame_written` in IDLE at cycle n (`I_image_valid`=1) → `O_swap_trigger`=1 at n+1, for exactly one cycle.
- `I_image_sent` at cycle n in SENDING with `pending` → `O_swap_trigger` at n+1.
- `I_swap_ack` is accepted from the cycle after the trigger onward. Ack at cycle m → `O_start_image` at m+1.
- Watchdog counts cycles after the trigger. With no ack, ERROR is entered and `O_error` rises at trigger+`ACK_TIMEOUT`+1. An ack on cycle trigger+`ACK_TIMEOUT` is still accepted.
- Repeat case: `O_start_image` at n+1 after `I_image_sent` at n.
- `O_frame_dropped` appears 1 cycle after the overwriting `I_frame_written`.
- `I_rst` mid-swap: SWAP is abandoned and no trigger or start follows until a new frame completes.

## Configuration
- `SWAP_STATS_EN` defined:
  - `O_drop_count` increments on every `O_frame_dropped`.
  - `O_repeat_count` increments on every repeat `O_start_image`.
  - Both saturate at all-ones and reset to 0.
- Not defined: both count ports are absent and no counter logic is generated.

## Structure
- Package `swap_sched_pkg`: FSM state enum `swap_state_t` (IDLE, SWAP, SENDING, WAIT_FRAME, ERROR) and the default `ACK_TIMEOUT` constant.
- One sub-module, `ack_watchdog`:
  - Inputs: `start`, `ack`; output: `timeout`.
  - Counter width `$clog2(ACK_TIMEOUT+1)`.

## Test plan
- Reset, then `I_image_valid`=1 and `I_frame_written` at cycle 10 → trigger at 11; ack at 15 → `O_start_image` at 16, `O_busy`=1.
- In SENDING, two `I_frame_written` pulses, then `I_image_sent` → one `O_frame_dropped`, a single swap follows, and `O_drop_count`=1 (stats build).
- In SENDING with no pending frame and `REPEAT_ON_STARVE`=1, `I_image_sent` → `O_start_image` next cycle and `O_repeat_count`=1.
- With `REPEAT_ON_STARVE`=0 the same stimulus → WAIT_FRAME, no start. A later `I_frame_written` → trigger one cycle after it.
- `ACK_TIMEOUT`=8, trigger with no ack → `O_error`=1 at trigger+9. Further frames produce no triggers until `I_rst`.
- `I_frame_written` in the same cycle the swap issues → `pending` remains 1, and the next `I_image_sent` causes another swap.
